// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the register file / scoreboard slice.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_busy_tracker.sv
// Busy-bit scoreboard: per-register pending-producer bits, set/clear priority,
// registered popcount and the RAW/WAW issue-stall decision. Honours REGFILE_WB_BYPASS_EN.
module regfile_busy_tracker
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_use,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic                       iss_valid,
  input  logic                       iss_wen,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_ready,
  output logic [ADDR_W:0]            busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic [DEPTH-1:0] wb_hit;
  logic [DEPTH-1:0] busy_vis;
  logic [ADDR_W:0]  busy_cnt_reg;
  logic [ADDR_W:0]  cnt_next;
  logic             raw_stall;
  logic             waw_stall;
  logic             set_en;

  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) wb_hit[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
    end
    wb_hit[0] = 1'b0;
  end

  // View of busy bits used by reads and hazard checks this cycle.
`ifdef REGFILE_WB_BYPASS_EN
  assign busy_vis = busy_reg & ~wb_hit;
`else
  assign busy_vis = busy_reg;
`endif

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_busy
    assign rd_busy[gi] = busy_vis[rd_addr[gi*ADDR_W +: ADDR_W]];
  end

  assign raw_stall = |(rd_use & rd_busy);
  assign waw_stall = iss_wen && (iss_addr != '0) && busy_vis[iss_addr];
  assign iss_ready = !raw_stall && !waw_stall;
  assign set_en    = iss_valid && iss_ready && iss_wen && (iss_addr != '0);

  // Clear first, then set, so a same-edge set keeps the bit busy.
  always_comb begin
    busy_next = busy_reg & ~wb_hit;
    if (set_en) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt_next = cnt_next + (ADDR_W+1)'(busy_next[k]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_reg     <= '0;
      busy_cnt_reg <= '0;
    end else begin
      busy_reg     <= busy_next;
      busy_cnt_reg <= cnt_next;
    end
  end

  assign busy_cnt = busy_cnt_reg;
endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with integrated busy-bit scoreboard.
// Define REGFILE_WB_BYPASS_EN to forward same-cycle write-back data and busy clears.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_use,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       iss_valid,
  input  logic                       iss_wen,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic                       iss_ready,
  output logic [ADDR_W:0]            busy_cnt
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_reg [DEPTH];

  // Later ports are scheduled last, so the highest-numbered port wins a conflict.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) regs_reg[k] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] != '0))
          regs_reg[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] word;
    assign ra = rd_addr[gi*ADDR_W +: ADDR_W];
    always_comb begin
      word = (ra == '0) ? '0 : regs_reg[ra];
`ifdef REGFILE_WB_BYPASS_EN
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (ra != '0) && (wr_addr[j*ADDR_W +: ADDR_W] == ra))
          word = wr_data[j*DATA_W +: DATA_W];
      end
`endif
    end
    assign rd_data[gi*DATA_W +: DATA_W] = word;
  end

  regfile_busy_tracker #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) u_busy (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_use    (rd_use),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard plus hand sequences for reset and bypass cases.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [1:0]  rd_use = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic        iss_valid = 1'b0;
  logic        iss_wen = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        iss_ready;
  logic [5:0]  busy_cnt;

  int n_checks = 0;
  int n_fail = 0;

  regfile_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_use    (rd_use),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    reg_idx_t    wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        iv, iw;
    reg_idx_t    ia;
    reg_idx_t    ra0, ra1;
    logic [1:0]  ru;
    logic [31:0] e_d0, e_d1;
    logic [1:0]  e_busy;
    logic        e_rdy;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_wen = 1'b0; iss_addr = '0;
    rd_addr = '0; rd_use = '0;
  endtask

  initial begin
    //          we    wa0 wa1 wd0           wd1       iv iw ia  ra0 ra1 ru     e_d0          e_d1      e_busy e_rdy e_cnt
    vecs[0]  = '{2'b00, 0, 0, 32'h0,        32'h0,    0, 0, 0,  0,  0, 2'b00, 32'h0,        32'h0,    2'b00, 1, 0};
    vecs[1]  = '{2'b11, 1, 2, 32'h11,       32'h22,   0, 0, 0,  3,  4, 2'b00, 32'h0,        32'h0,    2'b00, 1, 0};
    vecs[2]  = '{2'b00, 0, 0, 32'h0,        32'h0,    1, 1, 3,  1,  2, 2'b00, 32'h11,       32'h22,   2'b00, 1, 0};
    vecs[3]  = '{2'b00, 0, 0, 32'h0,        32'h0,    0, 0, 0,  3,  1, 2'b11, 32'h0,        32'h11,   2'b01, 0, 1};
    vecs[4]  = '{2'b00, 0, 0, 32'h0,        32'h0,    1, 1, 7,  3,  1, 2'b00, 32'h0,        32'h11,   2'b01, 1, 1};
    vecs[5]  = '{2'b00, 0, 0, 32'h0,        32'h0,    1, 1, 7,  7,  3, 2'b00, 32'h0,        32'h0,    2'b11, 0, 2};
    vecs[6]  = '{2'b01, 3, 0, 32'h12,       32'h0,    1, 1, 7,  7,  7, 2'b00, 32'h0,        32'h0,    2'b11, 0, 2};
    vecs[7]  = '{2'b00, 0, 0, 32'h0,        32'h0,    0, 0, 0,  3,  0, 2'b01, 32'h12,       32'h0,    2'b00, 1, 1};
    vecs[8]  = '{2'b11, 9, 9, 32'h1,        32'h2,    0, 0, 0,  1,  2, 2'b00, 32'h11,       32'h22,   2'b00, 1, 1};
    vecs[9]  = '{2'b01, 0, 0, 32'hFFFFFFFF, 32'h0,    1, 1, 0,  9,  0, 2'b00, 32'h2,        32'h0,    2'b00, 1, 1};
    vecs[10] = '{2'b10, 0, 7, 32'h0,        32'h77,   0, 0, 0,  0,  9, 2'b00, 32'h0,        32'h2,    2'b00, 1, 1};
    vecs[11] = '{2'b00, 0, 0, 32'h0,        32'h0,    0, 0, 0,  7,  0, 2'b01, 32'h77,       32'h0,    2'b00, 1, 0};
    vecs[12] = '{2'b01, 5, 0, 32'hDEADBEEF, 32'h0,    0, 0, 0,  1,  0, 2'b00, 32'h11,       32'h0,    2'b00, 1, 0};
    vecs[13] = '{2'b00, 0, 0, 32'h0,        32'h0,    1, 1, 5,  5,  0, 2'b01, 32'hDEADBEEF, 32'h0,    2'b00, 1, 0};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd_data0", -1, rd_data[31:0], 32'h0);
    chk("reset_busy_cnt", -1, 32'(busy_cnt), 32'h0);
    chk("reset_iss_ready", -1, 32'(iss_ready), 32'h1);
    reset = 1'b1;

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      wr_en = vecs[v].we;
      wr_addr = {vecs[v].wa1, vecs[v].wa0};
      wr_data = {vecs[v].wd1, vecs[v].wd0};
      iss_valid = vecs[v].iv; iss_wen = vecs[v].iw; iss_addr = vecs[v].ia;
      rd_addr = {vecs[v].ra1, vecs[v].ra0};
      rd_use = vecs[v].ru;
      #1;
      $display("vec %0d: rd_data0=0x%0h rd_data1=0x%0h rd_busy=%b iss_ready=%b busy_cnt=%0d",
               v, rd_data[31:0], rd_data[63:32], rd_busy, iss_ready, busy_cnt);
      chk("rd_data0", v, rd_data[31:0], vecs[v].e_d0);
      chk("rd_data1", v, rd_data[63:32], vecs[v].e_d1);
      chk("rd_busy", v, 32'(rd_busy), 32'(vecs[v].e_busy));
      chk("iss_ready", v, 32'(iss_ready), 32'(vecs[v].e_rdy));
      chk("busy_cnt", v, 32'(busy_cnt), 32'(vecs[v].e_cnt));
    end

    // Mid-cycle asynchronous reset: R5 holds data and is busy.
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd0, 5'd5}; rd_use = 2'b01;
    #1;
    chk("pre_reset_r5", 0, rd_data[31:0], 32'hDEADBEEF);
    chk("pre_reset_cnt", 0, 32'(busy_cnt), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    $display("async reset: rd_data0=0x%0h busy=%b ready=%b cnt=%0d", rd_data[31:0], rd_busy, iss_ready, busy_cnt);
    chk("async_reset_r5", 0, rd_data[31:0], 32'h0);
    chk("async_reset_cnt", 0, 32'(busy_cnt), 32'h0);
    chk("async_reset_busy", 0, 32'(rd_busy), 32'h0);
    chk("async_reset_ready", 0, 32'(iss_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1;

    // RAW dependency resolved by write-back.
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_addr = 5'd3;
    #1;
    chk("raw_issue_ready", 0, 32'(iss_ready), 32'h1);
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd0, 5'd3}; rd_use = 2'b01;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'h12};
    #1;
    $display("raw wb cycle: rd_data0=0x%0h busy=%b ready=%b cnt=%0d", rd_data[31:0], rd_busy, iss_ready, busy_cnt);
    chk("raw_wb_cnt", 0, 32'(busy_cnt), 32'h1);
`ifdef REGFILE_WB_BYPASS_EN
    chk("raw_wb_data", 0, rd_data[31:0], 32'h12);
    chk("raw_wb_busy", 0, 32'(rd_busy), 32'h0);
    chk("raw_wb_ready", 0, 32'(iss_ready), 32'h1);
`else
    chk("raw_wb_data", 0, rd_data[31:0], 32'h0);
    chk("raw_wb_busy", 0, 32'(rd_busy), 32'h1);
    chk("raw_wb_ready", 0, 32'(iss_ready), 32'h0);
`endif
    @(negedge clk);
    wr_en = 2'b00;
    #1;
    chk("raw_after_data", 0, rd_data[31:0], 32'h12);
    chk("raw_after_ready", 0, 32'(iss_ready), 32'h1);
    chk("raw_after_cnt", 0, 32'(busy_cnt), 32'h0);

    // Same-edge set and clear of R4.
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_addr = 5'd4;
    @(negedge clk);
    wr_en = 2'b10; wr_addr = {5'd4, 5'd0}; wr_data = {32'h44, 32'h0};
    #1;
    chk("setclr_cnt_before", 0, 32'(busy_cnt), 32'h1);
`ifdef REGFILE_WB_BYPASS_EN
    chk("setclr_ready", 0, 32'(iss_ready), 32'h1);
`else
    chk("setclr_ready", 0, 32'(iss_ready), 32'h0);
`endif
    @(negedge clk);
    idle_inputs();
    rd_addr = {5'd0, 5'd4};
    #1;
    $display("set/clear: rd_data0=0x%0h busy=%b cnt=%0d", rd_data[31:0], rd_busy, busy_cnt);
    chk("setclr_data", 0, rd_data[31:0], 32'h44);
`ifdef REGFILE_WB_BYPASS_EN
    chk("setclr_busy", 0, 32'(rd_busy), 32'h1);
    chk("setclr_cnt", 0, 32'(busy_cnt), 32'h1);
`else
    chk("setclr_busy", 0, 32'(rd_busy), 32'h0);
    chk("setclr_cnt", 0, 32'(busy_cnt), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
